vga_line_fetch_ctrl: RTL and testbench

- Scheduler sitting between the VGA timing generator and a shared frame-buffer read port.
- Sequences burst reads so that line N+1 is fetched into a ping-pong line buffer while line N is scanned out.
- Owns the read handshake, address generation, buffer bank selection and underrun detection.
- Runs entirely on CLOCK_50; timing inputs are single-cycle pulses/levels synchronous to CLOCK_50.

---
 rtl/vga_line_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_vga_line_fetch_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch_ctrl.sv
// rtl/vga_line_fetch_ctrl.sv - ping-pong line prefetch scheduler for the VGA frame-buffer read port
//
// Fetches line N+1 into one bank of a two-bank line buffer while the scan-out
// side reads line N from the other bank. Reads are issued as BURST_LEN-word
// bursts over a request/grant port; returned beats are registered into the
// line buffer one cycle later.
//
// Optional build macro: VGA_FETCH_STATS_EN adds underrun_cnt and frames_done.
//
// Ports:
//   CLOCK_50     system clock; every input is synchronous to it
//   RESET        synchronous, active-high reset
//   frame_start  one-cycle pulse at vsync start; restarts fetching at line 0
//   line_start   one-cycle pulse at the start of each visible line
//   rd_req       burst read request (high in REQ)
//   rd_addr      burst start word address, held while rd_req is high
//   rd_gnt       request accepted this cycle
//   rd_valid     read data beat valid
//   rd_data      read data beat
//   lb_we        line-buffer write strobe
//   lb_bank      bank currently being filled
//   lb_waddr     word index within the line
//   lb_wdata     registered rd_data
//   disp_bank    bank the scan-out side reads
//   busy         a fetch is in progress
//   underrun     sticky: a timing event arrived before a fetch completed
//   underrun_cnt saturating count of underrun events      (VGA_FETCH_STATS_EN)
//   frames_done  count of completed last-line fetches     (VGA_FETCH_STATS_EN)

module vga_line_fetch_ctrl #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int BURST_LEN   = 16,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 24,
  parameter int FB_BASE     = 0,
  parameter int LINE_STRIDE = 640
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        frame_start,
  input  logic                        line_start,
  output logic                        rd_req,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic                        rd_gnt,
  input  logic                        rd_valid,
  input  logic [DATA_W-1:0]           rd_data,
  output logic                        lb_we,
  output logic                        lb_bank,
  output logic [$clog2(H_PIXELS)-1:0] lb_waddr,
  output logic [DATA_W-1:0]           lb_wdata,
  output logic                        disp_bank,
  output logic                        busy,
  output logic                        underrun
`ifdef VGA_FETCH_STATS_EN
  ,
  output logic [15:0]                 underrun_cnt,
  output logic [15:0]                 frames_done
`endif
);

  localparam int NUM_BURSTS = H_PIXELS / BURST_LEN;
  localparam int WA_W       = $clog2(H_PIXELS);
  localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BI_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  // One extra code so fetch_line can hold V_LINES ("frame exhausted").
  localparam int FL_W       = $clog2(V_LINES + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BI_W-1:0]   LAST_BURST = BI_W'(NUM_BURSTS - 1);
  localparam logic [FL_W-1:0]   NUM_LINES  = FL_W'(V_LINES);
  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(LINE_STRIDE);
  localparam logic [ADDR_W-1:0] BURST_A    = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [FL_W-1:0]   fetch_line, fetch_line_nxt;
  logic [BI_W-1:0]   burst_idx, burst_idx_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic              lb_bank_nxt;
  logic              disp_bank_nxt;
  logic              underrun_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              lb_we_nxt;
  logic [WA_W-1:0]   lb_waddr_nxt;
  logic [DATA_W-1:0] lb_wdata_nxt;
  // Event that interrupted a fetch; replayed once the port is quiet again.
  logic              pend_valid, pend_valid_nxt;
  logic              pend_frame, pend_frame_nxt;
  logic              start_frame, start_line;
  logic              ev_any, ev_line;

  // Modulo 2^ADDR_W by construction: all terms are ADDR_W wide.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [FL_W-1:0] line,
                                                  input logic [BI_W-1:0] bidx);
    calc_addr = BASE_A + ADDR_W'(line) * STRIDE_A + ADDR_W'(bidx) * BURST_A;
  endfunction

  assign ev_any = frame_start | line_start;
  assign ev_line = line_start & ~frame_start;  // frame_start wins when coincident
  assign rd_req = (state == REQ);
  assign busy   = (state != IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= IDLE;
      fetch_line <= '0;
      burst_idx  <= '0;
      beat_cnt   <= '0;
      lb_bank    <= 1'b0;
      disp_bank  <= 1'b1;
      underrun   <= 1'b0;
      rd_addr    <= '0;
      lb_we      <= 1'b0;
      lb_waddr   <= '0;
      lb_wdata   <= '0;
      pend_valid <= 1'b0;
      pend_frame <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_line <= fetch_line_nxt;
      burst_idx  <= burst_idx_nxt;
      beat_cnt   <= beat_cnt_nxt;
      lb_bank    <= lb_bank_nxt;
      disp_bank  <= disp_bank_nxt;
      underrun   <= underrun_nxt;
      rd_addr    <= rd_addr_nxt;
      lb_we      <= lb_we_nxt;
      lb_waddr   <= lb_waddr_nxt;
      lb_wdata   <= lb_wdata_nxt;
      pend_valid <= pend_valid_nxt;
      pend_frame <= pend_frame_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_line_nxt = fetch_line;
    burst_idx_nxt  = burst_idx;
    beat_cnt_nxt   = beat_cnt;
    lb_bank_nxt    = lb_bank;
    disp_bank_nxt  = disp_bank;
    underrun_nxt   = underrun;
    rd_addr_nxt    = rd_addr;
    lb_we_nxt      = 1'b0;
    lb_waddr_nxt   = lb_waddr;
    lb_wdata_nxt   = lb_wdata;
    pend_valid_nxt = pend_valid;
    pend_frame_nxt = pend_frame;
    start_frame    = 1'b0;
    start_line     = 1'b0;

    case (state)
      IDLE: begin
        if (frame_start) begin
          start_frame = 1'b1;
        end else if (line_start) begin
          disp_bank_nxt = lb_bank;
          start_line    = 1'b1;
        end else if (pend_valid) begin
          // disp_bank already moved when the interrupting event arrived.
          start_frame = pend_frame;
          start_line  = ~pend_frame;
        end
        pend_valid_nxt = 1'b0;
      end

      REQ: begin
        if (ev_any) begin
          // No grant outstanding, so the request can simply be withdrawn.
          underrun_nxt   = 1'b1;
          disp_bank_nxt  = ev_line ? ~disp_bank : disp_bank;
          pend_valid_nxt = 1'b1;
          pend_frame_nxt = frame_start;
          fetch_line_nxt = fetch_line + FL_W'(1);
          state_nxt      = IDLE;
        end else if (rd_gnt) begin
          beat_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end

      XFER: begin
        if (ev_any) begin
          // The granted burst still delivers its remaining beats; the
          // partial line is abandoned and the next line is scheduled.
          underrun_nxt   = 1'b1;
          disp_bank_nxt  = ev_line ? ~disp_bank : disp_bank;
          pend_valid_nxt = 1'b1;
          pend_frame_nxt = frame_start;
          fetch_line_nxt = fetch_line + FL_W'(1);
          if (rd_valid && beat_cnt == LAST_BEAT) begin
            state_nxt = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + BEAT_W'(rd_valid);
            state_nxt    = DRAIN;
          end
        end else if (rd_valid) begin
          lb_we_nxt    = 1'b1;
          lb_wdata_nxt = rd_data;
          lb_waddr_nxt = WA_W'(burst_idx) * WA_W'(BURST_LEN) + WA_W'(beat_cnt);
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            if (burst_idx != LAST_BURST) begin
              burst_idx_nxt = burst_idx + BI_W'(1);
              rd_addr_nxt   = calc_addr(fetch_line, burst_idx + BI_W'(1));
              state_nxt     = REQ;
            end else begin
              fetch_line_nxt = fetch_line + FL_W'(1);
              state_nxt      = IDLE;
            end
          end else begin
            beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          end
        end
      end

      DRAIN: begin
        if (ev_any) begin
          underrun_nxt   = 1'b1;
          disp_bank_nxt  = ev_line ? ~disp_bank : disp_bank;
          pend_frame_nxt = pend_frame | frame_start;
        end
        if (rd_valid) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + BEAT_W'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Fetch launch shared by live and replayed events.
    if (start_frame) begin
      fetch_line_nxt = '0;
      lb_bank_nxt    = 1'b0;
      burst_idx_nxt  = '0;
      beat_cnt_nxt   = '0;
      rd_addr_nxt    = calc_addr('0, '0);
      state_nxt      = REQ;
    end else if (start_line && fetch_line < NUM_LINES) begin
      lb_bank_nxt   = ~lb_bank;
      burst_idx_nxt = '0;
      beat_cnt_nxt  = '0;
      rd_addr_nxt   = calc_addr(fetch_line, '0);
      state_nxt     = REQ;
    end
  end

`ifdef VGA_FETCH_STATS_EN
  localparam logic [FL_W-1:0] LAST_LINE = FL_W'(V_LINES - 1);

  logic ur_event;
  logic frame_done;

  assign ur_event   = busy & ev_any;
  assign frame_done = (state == XFER) & ~ev_any & rd_valid &
                      (beat_cnt == LAST_BEAT) & (burst_idx == LAST_BURST) &
                      (fetch_line == LAST_LINE);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      underrun_cnt <= '0;
      frames_done  <= '0;
    end else begin
      if (ur_event && underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
      if (frame_done) begin
        frames_done <= frames_done + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// tb/tb_vga_line_fetch_ctrl.sv - directed self-checking bench for vga_line_fetch_ctrl
module tb_vga_line_fetch_ctrl;

  localparam int H_PIXELS    = 32;
  localparam int V_LINES     = 4;
  localparam int BURST_LEN   = 8;
  localparam int ADDR_W      = 24;
  localparam int DATA_W      = 24;
  localparam int FB_BASE     = 'h100;
  localparam int LINE_STRIDE = 32;

  logic              CLOCK_50;
  logic              RESET;
  logic              frame_start;
  logic              line_start;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              lb_we;
  logic              lb_bank;
  logic [4:0]        lb_waddr;
  logic [DATA_W-1:0] lb_wdata;
  logic              disp_bank;
  logic              busy;
  logic              underrun;
`ifdef VGA_FETCH_STATS_EN
  logic [15:0]       underrun_cnt;
  logic [15:0]       frames_done;
`endif

  int n_pass;
  int n_fail;
  int n_total;

  vga_line_fetch_ctrl #(
    .H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .BURST_LEN(BURST_LEN),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_BASE(FB_BASE), .LINE_STRIDE(LINE_STRIDE)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .frame_start (frame_start),
    .line_start  (line_start),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .lb_we       (lb_we),
    .lb_bank     (lb_bank),
    .lb_waddr    (lb_waddr),
    .lb_wdata    (lb_wdata),
    .disp_bank   (disp_bank),
    .busy        (busy),
    .underrun    (underrun)
`ifdef VGA_FETCH_STATS_EN
    ,
    .underrun_cnt(underrun_cnt),
    .frames_done (frames_done)
`endif
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix(input int line, input int idx);
    pix = DATA_W'(32'hA50000 + line * 256 + idx);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_req"},    64'(rd_req),    64'(0));
    check({tag, "_rd_addr"},   64'(rd_addr),   64'(0));
    check({tag, "_lb_we"},     64'(lb_we),     64'(0));
    check({tag, "_lb_bank"},   64'(lb_bank),   64'(0));
    check({tag, "_lb_waddr"},  64'(lb_waddr),  64'(0));
    check({tag, "_lb_wdata"},  64'(lb_wdata),  64'(0));
    check({tag, "_disp_bank"}, 64'(disp_bank), 64'(1));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_underrun"},  64'(underrun),  64'(0));
`ifdef VGA_FETCH_STATS_EN
    check({tag, "_underrun_cnt"}, 64'(underrun_cnt), 64'(0));
`endif
  endtask

  // Entered at a sample point where a request is expected to be pending.
  task automatic run_burst(input int line, input int bidx, input logic bank);
    logic [ADDR_W-1:0] exp_addr;
    int base;
    base = bidx * BURST_LEN;
    exp_addr = ADDR_W'(FB_BASE + line * LINE_STRIDE + base);
    check("req_up", 64'(rd_req), 64'(1));
    check("req_addr", 64'(rd_addr), 64'(exp_addr));
    rd_gnt = 1'b1;
    tick;
    rd_gnt = 1'b0;
    check("req_drop", 64'(rd_req), 64'(0));
    for (int b = 0; b < BURST_LEN; b++) begin
      rd_valid = 1'b1;
      rd_data  = pix(line, base + b);
      tick;
      check("wr_we", 64'(lb_we), 64'(1));
      check("wr_bank_addr_data", 64'({lb_bank, lb_waddr, lb_wdata}),
            64'({bank, 5'(base + b), pix(line, base + b)}));
    end
    rd_valid = 1'b0;
    rd_data  = '0;
  endtask

  task automatic run_line(input int line, input logic bank);
    for (int i = 0; i < H_PIXELS / BURST_LEN; i++) run_burst(line, i, bank);
    check("busy_after_line", 64'(busy), 64'(0));
  endtask

  task automatic pulse_line;
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    RESET = 1'b1; frame_start = 1'b0; line_start = 1'b0;
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
    tick; tick;
    check_reset_vals("reset");
    RESET = 1'b0;

    // Stray handshake inputs while idle must be ignored.
    rd_gnt = 1'b1; rd_valid = 1'b1; rd_data = 24'h123456;
    tick; tick;
    check("idle_gnt_ignored", 64'(rd_req), 64'(0));
    check("idle_valid_ignored", 64'(lb_we), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;

    // Prefetch of line 0 into bank 0.
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check("frame_disp_unchanged", 64'(disp_bank), 64'(1));
    check("frame_busy", 64'(busy), 64'(1));
    run_line(0, 1'b0);

    // Ping-pong: line 1 into bank 1 while bank 0 is displayed.
    pulse_line;
    check("pp1_disp", 64'(disp_bank), 64'(0));
    run_line(1, 1'b1);

    // Line 2 into bank 0 with a 5-cycle grant stall on the first burst.
    pulse_line;
    check("pp2_disp", 64'(disp_bank), 64'(1));
    for (int k = 0; k < 5; k++) begin
      check("stall_req", 64'(rd_req), 64'(1));
      check("stall_addr", 64'(rd_addr), 64'(24'h140));
      tick;
    end
    run_line(2, 1'b0);

    // Line 3 is the last line of the frame.
    pulse_line;
    check("pp3_disp", 64'(disp_bank), 64'(0));
    run_line(3, 1'b1);

    // Frame exhausted: only disp_bank moves.
    pulse_line;
    check("eof_disp", 64'(disp_bank), 64'(1));
    for (int k = 0; k < 3; k++) begin
      check("eof_no_req", 64'(rd_req), 64'(0));
      check("eof_idle", 64'(busy), 64'(0));
      tick;
    end
    check("no_underrun_yet", 64'(underrun), 64'(0));

    // New frame re-requests at FB_BASE.
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check("frame2_disp", 64'(disp_bank), 64'(1));
    check("frame2_bank", 64'(lb_bank), 64'(0));
    run_line(0, 1'b0);

    // Underrun: line 1 aborted after 3 of 8 beats.
    pulse_line;
    check("ur_disp_before", 64'(disp_bank), 64'(0));
    check("ur_req_addr", 64'(rd_addr), 64'(24'h120));
    rd_gnt = 1'b1;
    tick;
    rd_gnt = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rd_valid = 1'b1;
      rd_data  = pix(1, b);
      tick;
      check("ur_pre_we", 64'(lb_we), 64'(1));
    end
    rd_valid = 1'b0;
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    check("ur_flag", 64'(underrun), 64'(1));
    check("ur_disp_toggle", 64'(disp_bank), 64'(1));
    check("ur_drain_busy", 64'(busy), 64'(1));
    for (int b = 0; b < 5; b++) begin
      rd_valid = 1'b1;
      rd_data  = 24'hDEAD00 + 24'(b);
      tick;
      check("drain_no_we", 64'(lb_we), 64'(0));
      check("drain_no_req", 64'(rd_req), 64'(0));
    end
    rd_valid = 1'b0;
    check("drain_done_idle", 64'(busy), 64'(0));
    tick;
    check("replay_req", 64'(rd_req), 64'(1));
    check("replay_addr_line2", 64'(rd_addr), 64'(24'h140));
    check("replay_bank", 64'(lb_bank), 64'(0));
    check("ur_sticky", 64'(underrun), 64'(1));

    // RESET in the middle of a transfer.
    rd_gnt = 1'b1;
    tick;
    rd_gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rd_valid = 1'b1;
      rd_data  = pix(2, b);
      tick;
      check("pre_rst_waddr", 64'(lb_waddr), 64'(b));
    end
    RESET = 1'b1;
    rd_data = 24'hBEEF01;
    tick;
    RESET = 1'b0;
    check_reset_vals("midrst");
    for (int b = 0; b < 3; b++) begin
      rd_data = 24'hBEEF10 + 24'(b);
      tick;
      check("post_rst_no_we", 64'(lb_we), 64'(0));
      check("post_rst_idle", 64'(busy), 64'(0));
      check("post_rst_wdata", 64'(lb_wdata), 64'(0));
    end
    rd_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
